// File: rtl/bus_arbiter_if.sv
// Requester-side bundle for the internal-bus arbiter: request operands in,
// grant/completion and bus-control strobes out.
interface bus_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DST_W = 8
);
  logic [N_REQ-1:0]       req;
  logic [3*N_REQ-1:0]     req_src;
  logic [DST_W*N_REQ-1:0] req_dst;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic [2:0]             bus_sel;
  logic                   mem_rd;
  logic [DST_W-1:0]       ld_en;
  logic                   busy;

  modport master (
    output req, req_src, req_dst,
    input  gnt, done, bus_sel, mem_rd, ld_en, busy
  );

  modport slave (
    input  req, req_src, req_dst,
    output gnt, done, bus_sel, mem_rd, ld_en, busy
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin owner of the 16-bit internal bus: grants one register transfer
// at a time, inserts a read wait for memory sources, then pulses the loads.
module bus_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DST_W    = 8,
  parameter int MEM_WAIT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  bus_arbiter_if.slave  bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, XFER = 2'd2} state_t;

  state_t           state, state_nx;
  logic [IW-1:0]    rr_ptr, rr_nx, own, own_nx, win, probe;
  logic             found;
  logic [N_REQ-1:0] elig, last_done, own_oh, win_oh;
  logic [N_REQ-1:0] gnt_q, gnt_nx, done_q, done_nx;
  logic [2:0]       cnt, cnt_nx, src_q, src_nx, sel_q, sel_nx;
  logic [DST_W-1:0] dst_q, dst_nx, ld_q, ld_nx;
  logic             mrd_q, mrd_nx, busy_q;

  logic [2:0]       src_a [N_REQ];
  logic [DST_W-1:0] dst_a [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    assign src_a[g] = bus.req_src[3*g +: 3];
    assign dst_a[g] = bus.req_dst[DST_W*g +: DST_W];
  end

  // A requester served last cycle still has req high; keep it out of this round.
  assign elig   = bus.req & ~last_done;
  assign own_oh = N_REQ'(1) << own;
  assign win_oh = N_REQ'(1) << win;

  always_comb begin
    found = 1'b0;
    win   = '0;
    probe = '0;
    for (int i = 0; i < N_REQ; i++) begin
      probe = IW'((int'(rr_ptr) + i) % N_REQ);
      if (!found && elig[probe]) begin
        found = 1'b1;
        win   = probe;
      end
    end
  end

  // Next-state and next-output values; every output is registered below.
  always_comb begin
    state_nx = state;
    rr_nx    = rr_ptr;
    own_nx   = own;
    cnt_nx   = cnt;
    src_nx   = src_q;
    dst_nx   = dst_q;
    sel_nx   = sel_q;
    gnt_nx   = '0;
    done_nx  = '0;
    mrd_nx   = 1'b0;
    ld_nx    = '0;
    case (state)
      IDLE: begin
        if (found) begin
          own_nx = win;
          src_nx = src_a[win];
          dst_nx = dst_a[win];
          gnt_nx = win_oh;
          sel_nx = src_a[win];
          if (src_a[win] < 3'd2 && MEM_WAIT > 0) begin
            state_nx = WAIT;
            cnt_nx   = 3'(MEM_WAIT);
            mrd_nx   = 1'b1;
          end else begin
            state_nx = XFER;
            ld_nx    = dst_a[win];
            done_nx  = win_oh;
          end
        end
      end
      WAIT: begin
        gnt_nx = own_oh;
        sel_nx = src_q;
        if (cnt == 3'd1) begin
          state_nx = XFER;
          cnt_nx   = '0;
          ld_nx    = dst_q;
          done_nx  = own_oh;
        end else begin
          cnt_nx = cnt - 3'd1;
          mrd_nx = 1'b1;
        end
      end
      XFER: begin
        state_nx = IDLE;
        rr_nx    = IW'((int'(own) + 1) % N_REQ);
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      own       <= '0;
      last_done <= '0;
      cnt       <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      sel_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      mrd_q     <= 1'b0;
      ld_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      rr_ptr    <= rr_nx;
      own       <= own_nx;
      last_done <= done_q;
      cnt       <= cnt_nx;
      src_q     <= src_nx;
      dst_q     <= dst_nx;
      sel_q     <= sel_nx;
      gnt_q     <= gnt_nx;
      done_q    <= done_nx;
      mrd_q     <= mrd_nx;
      ld_q      <= ld_nx;
      busy_q    <= (state_nx != IDLE);
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.bus_sel = sel_q;
  assign bus.mem_rd  = mrd_q;
  assign bus.ld_en   = ld_q;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: three instances with MEM_WAIT = 2, 0, 3
// share one clock/reset; expected transfers are queued when requests go in.
module tb_bus_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [ND-1:0][NR-1:0]    req;
  logic [ND-1:0][3*NR-1:0]  src;
  logic [ND-1:0][DW*NR-1:0] dst;
  logic [ND-1:0][NR-1:0]    gnt, done;
  logic [ND-1:0][2:0]       sel;
  logic [ND-1:0]            mrd, bsy;
  logic [ND-1:0][DW-1:0]    ld;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    bus_arbiter_if #(.N_REQ(NR), .DST_W(DW)) bi ();
    assign bi.req     = req[g];
    assign bi.req_src = src[g];
    assign bi.req_dst = dst[g];
    assign gnt[g]     = bi.gnt;
    assign done[g]    = bi.done;
    assign sel[g]     = bi.bus_sel;
    assign mrd[g]     = bi.mem_rd;
    assign ld[g]      = bi.ld_en;
    assign bsy[g]     = bi.busy;
    bus_arbiter #(.N_REQ(NR), .DST_W(DW),
                  .MEM_WAIT(g == 0 ? 2 : (g == 1 ? 0 : 3))) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bi)
    );
  end

  typedef struct {int d; int k; int sel; int ld; int cyc;} exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rem      [ND][NR];
  int drop     [ND][NR];
  int busy_cnt [ND];
  int mrd_cnt  [ND];
  int last_sel [ND];
  bit prev_done[ND];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input int d, input int k, input int s, input int l, input int c);
    exp_t e;
    e.d = d; e.k = k; e.sel = s; e.ld = l; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic rq(input int d, input int k, input int s, input int l);
    src[d][3*k +: 3]   = s[2:0];
    dst[d][DW*k +: DW] = l[DW-1:0];
    req[d][k]          = 1'b1;
  endtask

  function automatic int find(input int d);
    int ix;
    ix = -1;
    for (int i = 0; i < sb.size(); i++)
      if (ix < 0 && sb[i].d == d) ix = i;
    return ix;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < ND; d++) begin
      busy_cnt[d] = 0; mrd_cnt[d] = 0; last_sel[d] = 0; prev_done[d] = 1'b0;
      for (int k = 0; k < NR; k++) begin rem[d][k] = 0; drop[d][k] = 0; end
    end
  endtask

  task automatic clr_cnt();
    for (int d = 0; d < ND; d++) begin busy_cnt[d] = 0; mrd_cnt[d] = 0; end
  endtask

  // Observe every instance once per cycle, then play the requester role.
  task automatic mon();
    for (int d = 0; d < ND; d++) begin
      int ix;
      for (int k = 0; k < NR; k++)
        if (drop[d][k] > 0) begin
          drop[d][k]--;
          if (drop[d][k] == 0) req[d][k] = 1'b0;
        end
      if (prev_done[d]) begin
        chk("idle_gnt", gnt[d], 0);
        chk("idle_busy", bsy[d], 0);
      end
      if (done[d] != '0) begin
        ix = find(d);
        if (ix < 0) chk("extra_done", done[d], 0);
        else begin
          chk("done_vec", done[d], 1 << sb[ix].k);
          chk("done_gnt", gnt[d], 1 << sb[ix].k);
          chk("xfer_sel", sel[d], sb[ix].sel);
          chk("xfer_ld", ld[d], sb[ix].ld);
          chk("xfer_cyc", cyc, sb[ix].cyc);
          chk("xfer_mrd", mrd[d], 0);
          last_sel[d] = sb[ix].sel;
          sb.delete(ix);
        end
        for (int k = 0; k < NR; k++)
          if (done[d][k] && rem[d][k] > 0) begin
            rem[d][k]--;
            if (rem[d][k] == 0) drop[d][k] = 2;
          end
      end else begin
        chk("ld_quiet", ld[d], 0);
      end
      prev_done[d] = (done[d] != '0);
      if (mrd[d]) begin
        mrd_cnt[d]++;
        ix = find(d);
        if (ix >= 0) begin
          chk("wait_sel", sel[d], sb[ix].sel);
          chk("wait_gnt", gnt[d], 1 << sb[ix].k);
        end
      end
      if (bsy[d]) busy_cnt[d]++;
      else chk("hold_sel", sel[d], last_sel[d]);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mon();
    end
  endtask

  initial begin
    int c0;
    req = '0; src = '0; dst = '0;
    clear_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // quiet after reset
    for (int i = 0; i < 10; i++) begin
      step(1);
      for (int d = 0; d < ND; d++)
        chk("rst_out", {gnt[d], done[d], sel[d], mrd[d], ld[d], bsy[d]}, 0);
    end

    // single register transfer
    clr_cnt();
    rq(0, 0, 7, 8'h04); rem[0][0] = 1; push(0, 0, 7, 8'h04, cyc + 1);
    step(5);
    chk("reg_busy", busy_cnt[0], 1);
    chk("reg_mrd", mrd_cnt[0], 0);
    chk("reg_drain", sb.size(), 0);

    // memory source, MEM_WAIT=2
    clr_cnt();
    rq(0, 2, 0, 8'h01); rem[0][2] = 1; push(0, 2, 0, 8'h01, cyc + 3);
    step(6);
    chk("mw2_mrd", mrd_cnt[0], 2);
    chk("mw2_busy", busy_cnt[0], 3);
    chk("mw2_drain", sb.size(), 0);

    // memory source, MEM_WAIT=0
    clr_cnt();
    rq(1, 2, 0, 8'h01); rem[1][2] = 1; push(1, 2, 0, 8'h01, cyc + 1);
    step(4);
    chk("mw0_mrd", mrd_cnt[1], 0);
    chk("mw0_busy", busy_cnt[1], 1);

    // broadcast mask, then empty mask
    rq(1, 0, 2, 8'h22); rem[1][0] = 1; push(1, 0, 2, 8'h22, cyc + 1);
    step(4);
    rq(1, 3, 4, 8'h00); rem[1][3] = 1; push(1, 3, 4, 8'h00, cyc + 1);
    step(4);

    // lone requester held past done: one pulse only
    rq(1, 1, 3, 8'h80); rem[1][1] = 1; push(1, 1, 3, 8'h80, cyc + 1);
    step(6);
    chk("ndg_req", req[1][1], 0);
    chk("ndg_drain", sb.size(), 0);

    // operands latched at grant, MEM_WAIT=3
    clr_cnt();
    rq(2, 3, 1, 8'h10); rem[2][3] = 1; c0 = cyc; push(2, 3, 1, 8'h10, c0 + 4);
    step(1);
    src[2][9 +: 3]  = 3'd5;
    dst[2][24 +: 8] = 8'h22;
    step(6);
    chk("lat_mrd", mrd_cnt[2], 3);

    // req dropped while granted still completes
    rq(2, 0, 0, 8'h08); push(2, 0, 0, 8'h08, cyc + 4);
    step(2);
    req[2][0] = 1'b0;
    step(5);
    chk("drop_drain", sb.size(), 0);

    // reset during WAIT aborts without done
    rq(2, 1, 1, 8'h02);
    step(2);
    chk("abort_pre", mrd[2], 1);
    rst_n = 1'b0;
    #1;
    chk("abort_out", {gnt[2], done[2], sel[2], mrd[2], ld[2], bsy[2]}, 0);
    req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    step(6);

    // round robin with all four held; rr_ptr is 0 after reset
    for (int k = 0; k < NR; k++) begin rq(0, k, 3 + k, 1 << k); rem[0][k] = 2; end
    c0 = cyc;
    for (int i = 0; i < 2 * NR; i++)
      push(0, i % NR, 3 + i % NR, 1 << (i % NR), c0 + 1 + 2 * i);
    step(22);
    chk("rr_req", req[0], 0);

    chk("sb_left", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Shares the processor's single 16-bit internal bus between several micro-sequencer requesters. Each requester asks for one register transfer: a bus source code and a one-hot destination load mask. The block grants the bus round-robin and drives the bus-source select into the bus multiplexer. For memory sources it inserts a configurable read wait, then pulses the destination load enables for exactly one cycle.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `DST_W`, 8: width of the destination load-enable mask.
- `MEM_WAIT`, 1: wait cycles before a memory-sourced transfer (0..7).

- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester request level.
- `req_src`  in  3*N_REQ  bus source code; requester k uses bits [3k+2:3k]. Codes: 0 DataM, 1 InstM, 2 PC, 3 R, 4 S, 5 T, 6 U, 7 AC.
- `req_dst`  in  DST_W*N_REQ  one-hot-or-zero load mask; requester k uses bits [DST_W*k+DST_W-1:DST_W*k].
- `gnt`  out  N_REQ  one-hot grant, high from grant through transfer.
- `done`  out  N_REQ  one-cycle completion pulse to the granted requester.
- `bus_sel`  out  3  bus multiplexer select.
- `mem_rd`  out  1  memory read strobe during the wait phase of sources 0/1.
- `ld_en`  out  DST_W  destination register load enables.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, WAIT, XFER.
- **IDLE**
  - Eligible set = `req & ~last_done`. `last_done` is the `done` vector from the previous cycle, so a requester just served is never re-granted before it can drop `req`.
  - If the eligible set is non-empty, grant the first eligible index at or after `rr_ptr`, searching upward with wrap.
  - On grant, latch the winner's `req_src` and `req_dst` into internal registers and set `gnt[k]`.
  - Next state is WAIT if the latched source < 2 and `MEM_WAIT` > 0; otherwise XFER.
- **WAIT**
  - Drive `bus_sel` = latched source and `mem_rd` = 1.
  - Count down from `MEM_WAIT`; on the last count go to XFER.
- **XFER** (exactly one cycle)
  - Drive `bus_sel` = latched source, `ld_en` = latched mask, `done[k]` = 1, `gnt[k]` = 1.
  - Set `rr_ptr` = (k+1) mod N_REQ.
  - Go to IDLE. `gnt` clears on entering IDLE.
- Latched operands are used after the grant. Changes to `req_src`/`req_dst` after the grant edge have no effect.
- Requester contract: hold `req` until `done`; deassert in the cycle after `done`.
  - If a requester deasserts `req` while granted, the transfer still completes.
- Mask of zero: the transfer runs normally, with no load enables and a `done` pulse.
- Multi-hot mask: passed through unchanged (broadcast load).
- `bus_sel` holds its last driven value in IDLE, so the bus does not glitch.
- All outputs are registered.

## Timing
- Reset (asynchronous, immediate) clears:
  - state = IDLE, `rr_ptr` = 0, `last_done` = 0, counter = 0;
  - `gnt` = 0, `done` = 0, `bus_sel` = 0, `mem_rd` = 0, `ld_en` = 0, `busy` = 0.
- Reset mid-transfer aborts the transfer with no `done` pulse. Requesters must re-request after reset.
- Register source, request sampled at edge t: `gnt` from t+1, XFER/`ld_en`/`done` at cycle t+1, IDLE at t+2.
- Memory source: `mem_rd` high for cycles t+1..t+MEM_WAIT, XFER at t+MEM_WAIT+1.
- Sustained throughput: one register transfer every 2 cycles. The IDLE arbitration cycle between transfers is mandatory.
- Simultaneous requests: round-robin order starting at `rr_ptr`.
- Starvation bound: at most N_REQ-1 transfers by other requesters before a waiting requester is granted.
- A requester whose `req` rises while another is in WAIT/XFER is considered at the next IDLE.

## Test plan
- **Reset values:** after reset with `req`=0, all outputs are 0 for 10 cycles. Assert `rst_n`=0 during WAIT: outputs go to 0 immediately, no `done` pulse, state returns to IDLE.
- **Single register transfer:** `req`[0]=1, src=7, dst=8'h04. One cycle later: `gnt`=4'b0001, `bus_sel`=7, `ld_en`=8'h04, `done`=4'b0001, all in the same cycle. `busy` high for exactly 1 cycle.
- **Memory source wait:** `MEM_WAIT`=2, `req`[2]=1, src=0, dst=8'h01. Expect `mem_rd`=1 for 2 cycles with `bus_sel`=0, then `ld_en`=8'h01 and `done`[2] on the 3rd cycle after sampling. With `MEM_WAIT`=0, the same request completes in 1 cycle with `mem_rd` never high.
- **Round-robin fairness:** all four requesters held high continuously. Grant order is 0,1,2,3,0,1…, one `done` every 2 cycles. No index is granted twice within any 4 consecutive grants.
- **No double grant:** lone `req`[1] held one cycle past its `done`. Exactly one `done`[1] pulse. `gnt` stays 0 in the following IDLE.
- **Operand latching:** change `req_src`/`req_dst` in the cycle after the grant during a `MEM_WAIT`=3 transfer. `bus_sel` and `ld_en` still show the values sampled at the grant edge.
